// File: rtl/cba_sub_pkg.sv
// cba_sub_pkg: shared width, FSM state type and slice-count helper for the carry-bypass subtractor
package cba_sub_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic int nblk(input int dw, input int bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/cba_slice.sv
// cba_slice: combinational W-bit adder slice whose carry skips the ripple chain when every bit propagates
module cba_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic rc;

    // ripple sum, with the carry-out bypassed straight from cin on a full propagate run
    always_comb begin
        {rc, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        cout    = &(x ^ y) ? cin : rc;
    end

endmodule

// File: rtl/cba_sub_32.sv
// cba_sub_32: multi-cycle a - b - bin as a + ~b + ~bin, one bypass slice per clock; CBA_SUB_OVF_EN adds ovf
module cba_sub_32 #(
    parameter int DATA_W = 32,
    parameter int BLK_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bin,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] d,
    output logic              bout,
    output logic              out_valid,
    input  logic              out_ready
`ifdef CBA_SUB_OVF_EN
    ,
    output logic              ovf
`endif
);

    import cba_sub_pkg::*;

    localparam int NBLK = nblk(DATA_W, BLK_W);
    localparam int IW   = $clog2(NBLK + 1);

    if (DATA_W != cba_sub_pkg::DATA_W || DATA_W % BLK_W != 0) begin : g_bad_cfg
        $error("cba_sub_32: DATA_W must be 32 and divisible by BLK_W");
    end

    state_t            state, state_nx;
    logic [DATA_W-1:0] ra, rb;
    logic              carry;
    logic [IW-1:0]     idx;
    logic [BLK_W-1:0]  s;
    logic              cout;
    logic              last;

    assign last = idx == IW'(NBLK - 1);

    cba_slice #(.W(BLK_W)) u_slice (
        .x    (ra[idx*BLK_W +: BLK_W]),
        .y    (rb[idx*BLK_W +: BLK_W]),
        .cin  (carry),
        .s    (s),
        .cout (cout)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: accept, walk NBLK slices, then hold the result until taken
    always_comb begin
        state_nx = state == IDLE ? (in_valid  ? CALC : IDLE) :
                   state == CALC ? (last      ? DONE : CALC) :
                                   (out_ready ? IDLE : DONE);
    end

    // handshake outputs decoded from state
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // operand capture with ~b / ~bin, then one slice per cycle into d and the carry register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            carry <= 1'b0;
            idx   <= '0;
            d     <= '0;
            bout  <= 1'b0;
`ifdef CBA_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (in_valid) begin
                ra    <= a;
                rb    <= ~b;
                carry <= ~bin;
                idx   <= '0;
            end
        end else if (state == CALC) begin
            d[idx*BLK_W +: BLK_W] <= s;
            carry                 <= cout;
            idx                   <= idx + 1'b1;
            if (last) begin
                bout <= ~cout;
`ifdef CBA_SUB_OVF_EN
                ovf  <= (ra[DATA_W-1] == rb[DATA_W-1]) && (s[BLK_W-1] != ra[DATA_W-1]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_cba_sub_32.sv
// tb_cba_sub_32: scoreboard bench for cba_sub_32 covering vectors, backpressure, mid-op reset and random traffic
module tb_cba_sub_32;

    typedef struct packed {
        logic [31:0] d;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        bin = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, bout;
    logic [31:0] d;
`ifdef CBA_SUB_OVF_EN
    logic        ovf;
`endif

    int   checks = 0;
    int   passed = 0;
    exp_t q[$];

    logic [31:0] ta  [8] = '{32'd5, 32'd0, 32'd255664433, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, 32'h8000_0000, 32'h0001_0000};
    logic [31:0] tb  [8] = '{32'd3, 32'd1, 32'd33456865,  32'hFFFF_FFFF, 32'h1234_5678, 32'd0, 32'h0000_0001, 32'h0000_0001};
    logic        tbi [8] = '{1'b0,  1'b0,  1'b0,          1'b1,          1'b0,          1'b1,  1'b0,          1'b0};
    logic [31:0] td  [8] = '{32'd2, 32'hFFFF_FFFF, 32'd222207568, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_FFFF};
    logic        tbo [8] = '{1'b0,  1'b1,  1'b0,          1'b1,          1'b0,          1'b1,  1'b0,          1'b0};

    cba_sub_32 dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CBA_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ibin,
                         input logic [31:0] ed, input logic eb);
        int   n;
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; bin = ibin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n == 50) $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        else passed++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        e.d = ed; e.bout = eb; e.ovf = (ia[31] != ib[31]) && (ed[31] != ia[31]);
        q.push_back(e);
    endtask

    task automatic wait_result(output int cyc, output exp_t e);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = q.size() != 0 ? q.pop_front() : '0;
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready got=%b exp=1", in_ready);   else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (d !== 32'd0)        $display("FAIL reset_d got=%h exp=0", d);                 else passed++;
        checks++; if (bout !== 1'b0)      $display("FAIL reset_bout got=%b exp=0", bout);           else passed++;
`ifdef CBA_SUB_OVF_EN
        checks++; if (ovf !== 1'b0)       $display("FAIL reset_ovf got=%b exp=0", ovf);             else passed++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_vectors;
        int   cyc;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue(ta[i], tb[i], tbi[i], td[i], tbo[i]);
            wait_result(cyc, e);
            checks++; if (cyc != 4)           $display("FAIL vec%0d_latency got=%0d exp=4", i, cyc);       else passed++;
            checks++; if (d !== e.d)          $display("FAIL vec%0d_d got=%h exp=%h", i, d, e.d);          else passed++;
            checks++; if (bout !== e.bout)    $display("FAIL vec%0d_bout got=%b exp=%b", i, bout, e.bout); else passed++;
            checks++; if (in_ready !== 1'b0)  $display("FAIL vec%0d_ready_done got=%b exp=0", i, in_ready); else passed++;
`ifdef CBA_SUB_OVF_EN
            checks++; if (ovf !== e.ovf)      $display("FAIL vec%0d_ovf got=%b exp=%b", i, ovf, e.ovf);    else passed++;
`endif
            release_out;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL vec%0d_release out_valid=%b in_ready=%b exp=0/1", i, out_valid, in_ready);
            else passed++;
        end
    endtask

    task automatic test_backpressure;
        int   cyc;
        exp_t e;
        logic bad;
        issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hCC79_6877, 1'b0);
        wait_result(cyc, e);
        checks++; if (d !== e.d || bout !== e.bout)
            $display("FAIL bp_first d=%h bout=%b exp=%h/%b", d, bout, e.d, e.bout);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin a = 32'd1; b = 32'd2; bin = 1'b1; in_valid = 1'b1; end
            if (i == 4) in_valid = 1'b0;
            @(posedge clk);
            #1;
            checks++; if (d !== e.d || bout !== e.bout || in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL bp_hold%0d d=%h bout=%b in_ready=%b out_valid=%b exp=%h/%b/0/1", i, d, bout, in_ready, out_valid, e.d, e.bout);
            else passed++;
        end
        release_out;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        else passed++;
        bad = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            bad |= out_valid;
        end
        checks++; if (bad !== 1'b0) $display("FAIL bp_ignored_op out_valid_seen=%b exp=0", bad); else passed++;
    endtask

    task automatic test_reset_mid;
        int   cyc;
        exp_t e;
        logic seen;
        issue(32'd7, 32'd3, 1'b0, 32'd4, 1'b0);
        void'(q.pop_back());
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (d !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_reset d=%h out_valid=%b in_ready=%b exp=0/0/1", d, out_valid, in_ready);
        else passed++;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        checks++; if (seen !== 1'b0) $display("FAIL mid_reset_no_result out_valid_seen=%b exp=0", seen); else passed++;
        issue(32'd10, 32'd4, 1'b0, 32'd6, 1'b0);
        wait_result(cyc, e);
        checks++; if (cyc != 4 || d !== e.d || bout !== e.bout)
            $display("FAIL mid_reset_next cyc=%0d d=%h bout=%b exp=4/%h/%b", cyc, d, bout, e.d, e.bout);
        else passed++;
        release_out;
    endtask

    task automatic test_back_to_back;
        int          cyc;
        exp_t        e;
        logic [31:0] ra, rb;
        logic        rbin;
        logic [32:0] m;
        for (int i = 0; i < 12; i++) begin
            ra   = $urandom;
            rb   = (i % 4 == 0) ? ra : $urandom;
            rbin = 1'($urandom_range(0, 1));
            m    = {1'b0, ra} - {1'b0, rb} - {32'd0, rbin};
            issue(ra, rb, rbin, m[31:0], m[32]);
            wait_result(cyc, e);
            checks++; if (d !== e.d || bout !== e.bout)
                $display("FAIL b2b%0d d=%h bout=%b exp=%h/%b", i, d, bout, e.d, e.bout);
            else passed++;
            checks++; if (d + rb + {31'd0, rbin} !== ra)
                $display("FAIL b2b%0d_identity add=%h exp=%h", i, d + rb + {31'd0, rbin}, ra);
            else passed++;
`ifdef CBA_SUB_OVF_EN
            checks++; if (ovf !== e.ovf) $display("FAIL b2b%0d_ovf got=%b exp=%b", i, ovf, e.ovf); else passed++;
`endif
            release_out;
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
